// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between requesters, the weighted round-robin arbiter and
// the downstream consumer. The arbiter side uses the slave modport.
interface wrr_arbiter_if #(
    parameter int REQ_WIDTH = 16,
    parameter int WEIGHT_W  = 4
);
    localparam int IDX_W = $clog2(REQ_WIDTH);

    logic [1:0]                  mode;
    logic [REQ_WIDTH*WEIGHT_W-1:0] weight;
    logic [REQ_WIDTH-1:0]        req;
    logic [REQ_WIDTH-1:0]        last;
    logic                        gnt_ready;
    logic [REQ_WIDTH-1:0]        gnt;
    logic                        gnt_valid;
    logic [IDX_W-1:0]            gnt_port;
    logic [WEIGHT_W-1:0]         credit;

    modport slave (
        input  mode, weight, req, last, gnt_ready,
        output gnt, gnt_valid, gnt_port, credit
    );

    modport master (
        output mode, weight, req, last, gnt_ready,
        input  gnt, gnt_valid, gnt_port, credit
    );
endinterface

// File: rtl/wrr_arbiter.sv
// Registered arbiter with transaction locking, per-requester weights and a
// run-time choice of fixed priority, round robin or weighted round robin.
module wrr_arbiter #(
    parameter int REQ_WIDTH = 16,
    parameter int WEIGHT_W  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    wrr_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(REQ_WIDTH);
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(REQ_WIDTH - 1);
    localparam logic [REQ_WIDTH-1:0] ONE_HOT0   = REQ_WIDTH'(1);
    localparam logic [1:0]           MODE_FIXED = 2'd0;
    localparam logic [1:0]           MODE_WRR   = 2'd2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    // Returns {found, index} of the first request at or above ptr, wrapping.
    // Walking downwards lets the closest candidate overwrite the others.
    function automatic logic [IDX_W:0] find_first(
        input logic [REQ_WIDTH-1:0] r,
        input logic [IDX_W-1:0]     ptr
    );
        logic [IDX_W:0] cand;
        logic [IDX_W:0] result;
        result = '0;
        for (int k = REQ_WIDTH - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(REQ_WIDTH)) begin
                cand = cand - (IDX_W+1)'(REQ_WIDTH);
            end
            if (r[cand[IDX_W-1:0]]) begin
                result = {1'b1, cand[IDX_W-1:0]};
            end
        end
        return result;
    endfunction

    state_t               r_state, w_state_next;
    logic [REQ_WIDTH-1:0] r_gnt, w_gnt_next;
    logic [IDX_W-1:0]     r_port, w_port_next;
    logic [IDX_W-1:0]     r_ptr, w_ptr_next;
    logic [WEIGHT_W-1:0]  r_credit, w_credit_next;
    logic [1:0]           r_mode, w_mode_next;

    logic                 w_locked;
    logic                 w_owner_req;
    logic                 w_txn_end;
    logic                 w_keep;
    logic                 w_release;
    logic                 w_arb;
    logic [IDX_W-1:0]     w_port_inc;
    logic [IDX_W-1:0]     w_search_ptr;
    logic [IDX_W:0]       w_pick;
    logic                 w_found;
    logic [IDX_W-1:0]     w_win;
    logic [WEIGHT_W-1:0]  w_win_weight;
    logic [WEIGHT_W-1:0]  w_win_credit;

    assign w_locked    = (r_state == S_LOCK);
    assign w_owner_req = bus.req[r_port];
    assign w_txn_end   = w_locked && w_owner_req && bus.gnt_ready && bus.last[r_port];
    // r_mode is the mode captured when this grant was issued
    assign w_keep      = w_txn_end && (r_mode == MODE_WRR) && (r_credit > WEIGHT_W'(1));
    assign w_release   = (w_txn_end && !w_keep) || (w_locked && !w_owner_req);
    assign w_arb       = !w_locked || w_release;

    assign w_port_inc   = (r_port == LAST_IDX) ? '0 : r_port + 1'b1;
    assign w_ptr_next   = (w_release && (r_mode != MODE_FIXED)) ? w_port_inc : r_ptr;
    assign w_search_ptr = (bus.mode == MODE_FIXED) ? '0 : w_ptr_next;
    assign w_pick       = find_first(bus.req, w_search_ptr);
    assign w_found      = w_pick[IDX_W];
    assign w_win        = w_pick[IDX_W-1:0];
    assign w_win_weight = bus.weight[w_win*WEIGHT_W +: WEIGHT_W];
    assign w_win_credit = (w_win_weight == '0) ? WEIGHT_W'(1) : w_win_weight;

    always_comb begin
        w_state_next  = r_state;
        w_gnt_next    = r_gnt;
        w_port_next   = r_port;
        w_credit_next = r_credit;
        w_mode_next   = r_mode;
        if (w_keep) begin
            w_credit_next = r_credit - 1'b1;
        end else if (w_arb) begin
            if (w_found) begin
                w_state_next  = S_LOCK;
                w_gnt_next    = ONE_HOT0 << w_win;
                w_port_next   = w_win;
                w_credit_next = w_win_credit;
                w_mode_next   = bus.mode;
            end else begin
                w_state_next  = S_IDLE;
                w_gnt_next    = '0;
                w_port_next   = '0;
                w_credit_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_port   <= '0;
            r_ptr    <= '0;
            r_credit <= '0;
            r_mode   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_gnt    <= w_gnt_next;
            r_port   <= w_port_next;
            r_ptr    <= w_ptr_next;
            r_credit <= w_credit_next;
            r_mode   <= w_mode_next;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_valid = |r_gnt;
    assign bus.gnt_port  = r_port;
    assign bus.credit    = r_credit;
endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_wrr_arbiter;
    localparam int N  = 16;
    localparam int WW = 4;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    wrr_arbiter_if #(.REQ_WIDTH(N), .WEIGHT_W(WW)) bus ();

    wrr_arbiter #(.REQ_WIDTH(N), .WEIGHT_W(WW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model state: who owns the grant (-1 = nobody), its remaining budget,
    // the round-robin start point and the mode the grant was issued under.
    typedef struct {
        int owner;
        int credit;
        int ptr;
        int mode;
    } mstate_t;

    mstate_t ms;

    function automatic int pick(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic mstate_t grant(input mstate_t s, input int w, input logic [1:0] md,
                                      input logic [N*WW-1:0] wv);
        mstate_t n = s;
        int      wt;
        wt       = int'(wv[w*WW +: WW]);
        n.owner  = w;
        n.credit = (wt == 0) ? 1 : wt;
        n.mode   = int'(md);
        return n;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic [1:0] md,
                                           input logic [N*WW-1:0] wv, input logic [N-1:0] r,
                                           input logic [N-1:0] l, input logic rdy);
        mstate_t n   = s;
        bit      rel = 0;
        int      w;
        if (s.owner < 0) begin
            w = pick(r, (md == 2'd0) ? 0 : s.ptr);
            if (w >= 0) n = grant(n, w, md, wv);
        end else if (!r[s.owner]) begin
            rel = 1;
        end else if (rdy && l[s.owner]) begin
            if (s.mode == 2 && s.credit > 1) n.credit = s.credit - 1;
            else rel = 1;
        end
        if (rel) begin
            if (s.mode != 0) n.ptr = (s.owner + 1) % N;
            w = pick(r, (md == 2'd0) ? 0 : n.ptr);
            if (w >= 0) begin
                n = grant(n, w, md, wv);
            end else begin
                n.owner  = -1;
                n.credit = 0;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_gnt(input mstate_t s);
        logic [31:0] g;
        g = '0;
        if (s.owner >= 0) g[s.owner] = 1'b1;
        return g;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ms <= '{owner: -1, credit: 0, ptr: 0, mode: 0};
        else ms <= model_next(ms, bus.mode, bus.weight, bus.req, bus.last, bus.gnt_ready);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_gnt", 32'(bus.gnt), exp_gnt(ms));
            chk("model_port", 32'(bus.gnt_port), (ms.owner >= 0) ? ms.owner : 0);
            chk("model_valid", 32'(bus.gnt_valid), 32'(ms.owner >= 0));
            chk("model_credit", 32'(bus.credit), (ms.owner >= 0) ? ms.credit : 0);
            chk("inv_onehot", 32'($onehot0(bus.gnt)), 32'd1);
            chk("inv_credit_nonzero", 32'(bus.gnt_valid && bus.credit == '0), 32'd0);
        end
    end

    initial begin
        int exp_port[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int exp_cred[8] = '{3, 2, 1, 1, 3, 2, 1, 1};
        logic [N-1:0] nr;

        rst_n         = 1'b0;
        bus.mode      = 2'd0;
        bus.weight    = '0;
        bus.req       = '0;
        bus.last      = '0;
        bus.gnt_ready = 1'b0;
        step(); step(); step();
        chk("reset_gnt", 32'(bus.gnt), 32'h0);
        chk("reset_valid", 32'(bus.gnt_valid), 32'h0);
        chk("reset_port", 32'(bus.gnt_port), 32'h0);
        chk("reset_credit", 32'(bus.credit), 32'h0);

        // Round robin between ports 0 and 2, one beat per transaction
        rst_n         = 1'b1;
        bus.mode      = 2'd1;
        bus.last      = '1;
        bus.gnt_ready = 1'b1;
        bus.req       = 16'h0005;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_gnt", 32'(bus.gnt), (k % 2) ? 32'h4 : 32'h1);
            chk("rr_port", 32'(bus.gnt_port), (k % 2) ? 32'd2 : 32'd0);
        end
        bus.req = '0;
        step();

        // Weighted: port 0 gets three transactions per turn, port 1 one
        bus.mode        = 2'd2;
        bus.weight      = '0;
        bus.weight[3:0] = 4'd3;
        bus.weight[7:4] = 4'd1;
        bus.req         = 16'h0003;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("wrr_port", 32'(bus.gnt_port), exp_port[k]);
            chk("wrr_credit", 32'(bus.credit), exp_cred[k]);
            chk("wrr_valid", 32'(bus.gnt_valid), 32'd1);
        end
        bus.req = '0;
        step();

        // Multi-beat lock on port 4 while port 7 starts requesting
        bus.mode      = 2'd1;
        bus.last      = '0;
        bus.gnt_ready = 1'b0;
        bus.req       = 16'h0010;
        step();
        chk("lock_start", 32'(bus.gnt), 32'h0010);
        for (int j = 0; j < 5; j++) begin
            bus.gnt_ready = (j != 1);
            if (j == 2) bus.req = 16'h0090;
            if (j == 4) bus.last = 16'h0010;
            step();
            chk("lock_hold", 32'(bus.gnt), (j < 4) ? 32'h0010 : 32'h0080);
        end
        bus.req  = '0;
        bus.last = '0;
        step();

        // Walk the pointer back to 0 via port 15, then fixed priority
        bus.last      = '1;
        bus.gnt_ready = 1'b1;
        bus.req       = 16'h8000;
        step();
        chk("fp_prep", 32'(bus.gnt), 32'h8000);
        bus.req = '0;
        step();
        bus.mode = 2'd0;
        bus.req  = 16'h8001;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("fp_gnt", 32'(bus.gnt), 32'h0001);
        end
        bus.req = '0;
        step();
        chk("fp_idle", 32'(bus.gnt), 32'h0);
        bus.mode = 2'd1;
        bus.req  = 16'h8001;
        step();
        chk("fp_ptr_unmoved", 32'(bus.gnt), 32'h0001);
        step();
        chk("fp_then_rr", 32'(bus.gnt), 32'h8000);
        bus.req = '0;
        step();

        // Abort with nobody else waiting, then pointer wrap from 4
        bus.last = '0;
        bus.req  = 16'h0008;
        step();
        chk("abort_grant", 32'(bus.gnt_port), 32'd3);
        step();
        chk("abort_hold", 32'(bus.gnt), 32'h0008);
        bus.req = '0;
        step();
        chk("abort_gnt", 32'(bus.gnt), 32'h0);
        chk("abort_valid", 32'(bus.gnt_valid), 32'd0);
        chk("abort_credit", 32'(bus.credit), 32'd0);
        bus.req = 16'h0009;
        step();
        chk("wrap_gnt", 32'(bus.gnt), 32'h0001);
        bus.req = '0;
        step();

        // Zero weight loads credit 1; asynchronous reset mid-lock
        bus.mode          = 2'd2;
        bus.weight[23:20] = 4'd0;
        bus.req           = 16'h0020;
        step();
        chk("w0_port", 32'(bus.gnt_port), 32'd5);
        chk("w0_credit", 32'(bus.credit), 32'd1);
        step();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(bus.gnt), 32'h0);
        chk("arst_valid", 32'(bus.gnt_valid), 32'd0);
        chk("arst_port", 32'(bus.gnt_port), 32'd0);
        chk("arst_credit", 32'(bus.credit), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.mode = 2'd1;
        bus.req  = 16'h0021;
        step();
        chk("arst_ptr", 32'(bus.gnt), 32'h0001);
        bus.req = '0;
        step();

        // Randomized traffic, one mode per phase
        for (int ph = 0; ph < 6; ph++) begin
            bus.req  = '0;
            bus.last = '0;
            step(); step();
            bus.mode   = 2'(ph % 4);
            bus.weight = {$urandom, $urandom};
            for (int c = 0; c < 400; c++) begin
                nr = bus.req;
                for (int i = 0; i < N; i++) begin
                    if (ms.owner == i) nr[i] = ($urandom_range(0, 99) >= 3);
                    else if (nr[i]) nr[i] = ($urandom_range(0, 99) >= 8);
                    else nr[i] = ($urandom_range(0, 99) < 15);
                end
                bus.req       = nr;
                bus.last      = 16'($urandom & $urandom);
                bus.gnt_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) bus.weight = {$urandom, $urandom};
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
